// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_ctrl_pkg
// Brief    : State, opcode and datapath-select encodings for the multicycle
//            MIPS main controller. MIPS_CTRL_BNE_EN adds the BNE state.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`ifdef MIPS_CTRL_BNE_EN
    S_BNE    = 4'd12,
`endif
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl
// Brief    : Moore main controller for the multicycle MIPS datapath.
//            Define MIPS_CTRL_BNE_EN to add bne support (pc_write_cond_ne).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] opcode,
  output logic           pc_write,
  output logic           pc_write_cond,
`ifdef MIPS_CTRL_BNE_EN
  output logic           pc_write_cond_ne,
`endif
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic [STW-1:0] state,
  output logic           illegal_op
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal_op;
  logic   w_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= r_illegal_op | w_illegal;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_illegal     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    pc_write_cond_ne = 1'b0;
`endif
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       w_next = S_BNE;
`endif
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (r_state == S_ADDIEX)  w_next = S_ADDIWB;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BNE: begin
        alu_src_a        = 1'b1;
        alu_op           = ALUOP_SUB;
        pc_write_cond_ne = 1'b1;
        pc_source        = PCSRC_ALUOUT;
      end
`endif
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign state      = STW'(r_state);
  assign illegal_op = r_illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_multicycle_ctrl
// Brief    : Directed self-checking bench for mips_multicycle_ctrl
//            (follows MIPS_CTRL_BNE_EN when defined).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
`ifdef MIPS_CTRL_BNE_EN
  logic       pc_write_cond_ne;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
`ifdef MIPS_CTRL_BNE_EN
    .pc_write_cond_ne (pc_write_cond_ne),
`endif
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal_op    (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, check the state and the strobe-exclusivity rules.
  task automatic tick(input logic [3:0] exp_state);
    @(negedge clk);
    chk("state", 32'(state), 32'(exp_state));
    chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    chk("regw_memw_excl", 32'(reg_write & mem_write), 32'd0);
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, "_state"},     32'(state),     32'd0);
    chk({tag, "_mem_read"},  32'(mem_read),  32'd1);
    chk({tag, "_ir_write"},  32'(ir_write),  32'd1);
    chk({tag, "_pc_write"},  32'(pc_write),  32'd1);
    chk({tag, "_alu_src_b"}, 32'(alu_src_b), 32'd1);
    chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
    chk({tag, "_illegal"},   32'(illegal_op), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = 6'b000000;
    repeat (2) @(negedge clk);
    chk_fetch("in_reset");
    reset_n = 1'b1;

    // lw: 0,1,2,3,4 then back to 0
    opcode = 6'b100011;
    tick(4'd1);
    chk("dec_alu_src_b", 32'(alu_src_b), 32'd3);
    tick(4'd2);
    chk("madr_src_a", 32'(alu_src_a), 32'd1);
    chk("madr_src_b", 32'(alu_src_b), 32'd2);
    tick(4'd3);
    chk("mrd_iord", 32'(iord), 32'd1);
    chk("mrd_mem_read", 32'(mem_read), 32'd1);
    chk("mrd_reg_write", 32'(reg_write), 32'd0);
    tick(4'd4);
    chk("mwb_reg_write", 32'(reg_write), 32'd1);
    chk("mwb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("mwb_reg_dst", 32'(reg_dst), 32'd0);
    tick(4'd0);
    chk("lw_done_mem_to_reg", 32'(mem_to_reg), 32'd0);

    // sw: 0,1,2,5
    opcode = 6'b101011;
    tick(4'd1);
    tick(4'd2);
    tick(4'd5);
    chk("mwr_mem_write", 32'(mem_write), 32'd1);
    chk("mwr_iord", 32'(iord), 32'd1);
    tick(4'd0);

    // R-type: 0,1,6,7
    opcode = 6'b000000;
    tick(4'd1);
    tick(4'd6);
    chk("exec_alu_op", 32'(alu_op), 32'd2);
    chk("exec_src_a", 32'(alu_src_a), 32'd1);
    chk("exec_src_b", 32'(alu_src_b), 32'd0);
    tick(4'd7);
    chk("rwb_reg_write", 32'(reg_write), 32'd1);
    chk("rwb_reg_dst", 32'(reg_dst), 32'd1);
    chk("rwb_mem_to_reg", 32'(mem_to_reg), 32'd0);
    tick(4'd0);

    // beq: 0,1,8
    opcode = 6'b000100;
    tick(4'd1);
    tick(4'd8);
    chk("beq_alu_op", 32'(alu_op), 32'd1);
    chk("beq_pwc", 32'(pc_write_cond), 32'd1);
    chk("beq_pc_source", 32'(pc_source), 32'd1);
    chk("beq_pc_write", 32'(pc_write), 32'd0);
    tick(4'd0);

    // j: 0,1,11
    opcode = 6'b000010;
    tick(4'd1);
    tick(4'd11);
    chk("j_pc_write", 32'(pc_write), 32'd1);
    chk("j_pc_source", 32'(pc_source), 32'd2);
    chk("j_pwc", 32'(pc_write_cond), 32'd0);
    tick(4'd0);

    // illegal opcode then addi; flag is sticky
    opcode = 6'b111111;
    tick(4'd1);
    chk("ill_not_yet", 32'(illegal_op), 32'd0);
    tick(4'd0);
    chk("ill_set", 32'(illegal_op), 32'd1);
    opcode = 6'b001000;
    tick(4'd1);
    tick(4'd9);
    chk("addiex_src_b", 32'(alu_src_b), 32'd2);
    tick(4'd10);
    chk("addiwb_reg_write", 32'(reg_write), 32'd1);
    chk("addiwb_reg_dst", 32'(reg_dst), 32'd0);
    chk("ill_sticky", 32'(illegal_op), 32'd1);
    tick(4'd0);

    // Reset asserted mid-EXEC aborts immediately
    opcode = 6'b000000;
    tick(4'd1);
    tick(4'd6);
    reset_n = 1'b0;
    #1;
    chk_fetch("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_reset_state", 32'(state), 32'd0);

    // bne opcode
    opcode = 6'b000101;
    tick(4'd1);
`ifdef MIPS_CTRL_BNE_EN
    tick(4'd12);
    chk("bne_pwc_ne", 32'(pc_write_cond_ne), 32'd1);
    chk("bne_pwc", 32'(pc_write_cond), 32'd0);
    chk("bne_pc_source", 32'(pc_source), 32'd1);
    chk("bne_alu_op", 32'(alu_op), 32'd1);
    chk("bne_legal", 32'(illegal_op), 32'd0);
    tick(4'd0);
`else
    tick(4'd0);
    chk("bne_illegal", 32'(illegal_op), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM main controller for the multicycle MIPS datapath.
- Sequences the shared ALU, memory, IR, register file and PC across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Drives the 2-bit ALUOp consumed by the existing ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct.
- Sits beside the datapath top; its only input is the IR opcode field.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state encoding width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- opcode  input  OPW  IR[31:26], valid from DECODE onward
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- mem_to_reg  output  1  write-back select: 1 = MDR
- reg_dst  output  1  destination select: 1 = rd, 0 = rt
- reg_write  output  1  register file write
- alu_src_a  output  1  ALU A: 0 = PC, 1 = A
- alu_src_b  output  2  ALU B: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- alu_op  output  2  to ALU control
- pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- state  output  STW  current state, for debug/bench
- illegal_op  output  1  sticky flag: unsupported opcode seen

Behaviour:
- Asynchronous reset (reset_n = 0):
  - state = FETCH (0); illegal_op = 0.
  - All outputs are combinational from state, so during reset they equal FETCH values.
  - Datapath registers are held in reset by the same signal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unused and return to FETCH on the next edge.
- Outputs per state (any output not listed is 0):
  - FETCH: mem_read, ir_write, pc_write = 1; alu_src_b = 01; alu_op = 00; pc_source = 00.
  - DECODE: alu_src_b = 11; alu_op = 00 (branch target into ALUOut).
  - MEMADR, ADDIEX: alu_src_a = 1; alu_src_b = 10; alu_op = 00.
  - MEMRD: mem_read = 1; iord = 1.
  - MEMWB: reg_write = 1; mem_to_reg = 1; reg_dst = 0.
  - MEMWR: mem_write = 1; iord = 1.
  - EXEC: alu_src_a = 1; alu_src_b = 00; alu_op = 10.
  - RWB: reg_write = 1; reg_dst = 1; mem_to_reg = 0.
  - BEQ: alu_src_a = 1; alu_src_b = 00; alu_op = 01; pc_write_cond = 1; pc_source = 01.
  - ADDIWB: reg_write = 1; reg_dst = 0; mem_to_reg = 0.
  - JUMP: pc_write = 1; pc_source = 10.
- Transitions:
  - FETCH -> DECODE unconditionally.
  - DECODE on opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - DECODE on any other opcode -> FETCH and set illegal_op = 1 on the same edge. The instruction is skipped; PC was already advanced in FETCH.
  - MEMADR: lw -> MEMRD; sw -> MEMWR. Opcode is held stable by the IR (ir_write is 0 outside FETCH).
  - MEMRD -> MEMWB.
  - EXEC -> RWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RWB, BEQ, ADDIWB, JUMP -> FETCH.
- Latency in cycles, FETCH included: lw 5; sw, R-type, addi 4; beq, j 3.
- illegal_op clears only on reset.
- Reset mid-instruction aborts immediately; no partial writes beyond the current cycle's combinational strobes.
- At most one of mem_read/mem_write is asserted in any state; reg_write and mem_write are never asserted together.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - Adds output pc_write_cond_ne (1 bit) and state BNE (12).
  - DECODE on opcode 000101 -> BNE.
  - BNE outputs equal BEQ except pc_write_cond = 0 and pc_write_cond_ne = 1; datapath loads PC when zero = 0.
  - BNE -> FETCH.
- Undefined: port is absent; opcode 000101 is illegal.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - ALUOp constants (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10);
  - alu_src_b and pc_source select constants.
- No sub-module; next-state and output decode stay in one module.

Test Plan:
- Reset low mid-EXEC, release -> state = 0, mem_read = 1, ir_write = 1, pc_write = 1, alu_src_b = 01, illegal_op = 0.
- opcode = 100011 -> states 0, 1, 2, 3, 4, 0 over 5 cycles; reg_write = 1 and mem_to_reg = 1 only in state 4; iord = 1 in state 3.
- opcode = 000000 -> states 0, 1, 6, 7; alu_op = 10 in state 6; reg_write = 1 and reg_dst = 1 in state 7.
- opcode = 000100, then 000010 -> beq: alu_op = 01, pc_write_cond = 1, pc_source = 01 in state 8; j: pc_write = 1, pc_source = 10 in state 11; 3 cycles each.
- opcode = 111111 -> DECODE returns to FETCH, illegal_op rises and stays 1 through a following valid addi (states 0, 1, 9, 10).
- With MIPS_CTRL_BNE_EN, opcode = 000101 -> state 12, pc_write_cond_ne = 1, pc_write_cond = 0; without it -> illegal_op = 1.
